// File: rtl/arbiter_if.sv
// Bundle between the two producing slaves, master 0's FIFO side and the arbiter.
// The arbiter uses the master modport; the producers/FIFO side use the slave modport.
interface arbiter_if #(
  parameter int DW = 32
);
  logic          mstr0_cmplt;
  logic          fifo_full;

  logic [1:0]    slv0_mode;
  logic          slv0_data_valid;
  logic [7:0]    slv0_proc_valid;
  logic [DW-1:0] slv0_data;
  logic          slv0_ready;

  logic [1:0]    slv1_mode;
  logic          slv1_data_valid;
  logic [7:0]    slv1_proc_valid;
  logic [DW-1:0] slv1_data;
  logic          slv1_ready;

  logic [1:0]    slvx_mode;
  logic          slvx_data_valid;
  logic [7:0]    slvx_proc_val;
  logic [DW-1:0] slvx_data;

  modport master (
    input  mstr0_cmplt,
    input  fifo_full,
    input  slv0_mode,
    input  slv0_data_valid,
    input  slv0_proc_valid,
    input  slv0_data,
    output slv0_ready,
    input  slv1_mode,
    input  slv1_data_valid,
    input  slv1_proc_valid,
    input  slv1_data,
    output slv1_ready,
    output slvx_mode,
    output slvx_data_valid,
    output slvx_proc_val,
    output slvx_data
  );

  modport slave (
    output mstr0_cmplt,
    output fifo_full,
    output slv0_mode,
    output slv0_data_valid,
    output slv0_proc_valid,
    output slv0_data,
    input  slv0_ready,
    output slv1_mode,
    output slv1_data_valid,
    output slv1_proc_valid,
    output slv1_data,
    input  slv1_ready,
    input  slvx_mode,
    input  slvx_data_valid,
    input  slvx_proc_val,
    input  slvx_data
  );
endinterface

// File: rtl/arbiter.sv
// Two-slave to one-master stream arbiter with registered beat forwarding.
// Define ARBITER_FIXED_PRI_EN for fixed priority (slave 0 wins); default is round-robin.
module arbiter #(
  parameter int DW = 32
) (
  input  logic      clk,
  input  logic      rst,
  arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Slave-side signals gathered into index-able form so per-slave logic is uniform.
  logic [1:0]    valid_vec;
  logic [1:0]    granted_vec;
  logic [1:0]    ready_vec;
  logic [1:0]    xfer_vec;
  logic [1:0]    mode_arr [2];
  logic [7:0]    pv_arr   [2];
  logic [DW-1:0] data_arr [2];

  assign valid_vec   = {bus.slv1_data_valid, bus.slv0_data_valid};
  assign granted_vec = {state_reg == GRANT1, state_reg == GRANT0};
  assign mode_arr[0] = bus.slv0_mode;
  assign mode_arr[1] = bus.slv1_mode;
  assign pv_arr[0]   = bus.slv0_proc_valid;
  assign pv_arr[1]   = bus.slv1_proc_valid;
  assign data_arr[0] = bus.slv0_data;
  assign data_arr[1] = bus.slv1_data;

  // Completion kills ready immediately so no beat is taken on the release edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign ready_vec[gi] = granted_vec[gi] & ~bus.fifo_full & ~bus.mstr0_cmplt;
      assign xfer_vec[gi]  = ready_vec[gi] & valid_vec[gi];
    end
  endgenerate

  assign bus.slv0_ready = ready_vec[0];
  assign bus.slv1_ready = ready_vec[1];

  // Slave picked when both request from IDLE.
  logic contend_pick;

`ifdef ARBITER_FIXED_PRI_EN
  assign contend_pick = 1'b0;
`else
  logic last_grant_reg;

  assign contend_pick = ~last_grant_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (state_reg == IDLE && state_next != IDLE) begin
      last_grant_reg <= (state_next == GRANT1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (valid_vec == 2'b11) begin
          state_next = contend_pick ? GRANT1 : GRANT0;
        end else if (valid_vec[0]) begin
          state_next = GRANT0;
        end else if (valid_vec[1]) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (bus.mstr0_cmplt || !valid_vec[0]) begin
          state_next = IDLE;
        end
      end
      GRANT1: begin
        if (bus.mstr0_cmplt || !valid_vec[1]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // At most one xfer bit can be set, so bit 1 alone selects the source.
  logic xfer_any;
  logic xfer_sel;

  assign xfer_any = |xfer_vec;
  assign xfer_sel = xfer_vec[1];

  logic [1:0]    slvx_mode_reg;
  logic          slvx_data_valid_reg;
  logic [7:0]    slvx_proc_val_reg;
  logic [DW-1:0] slvx_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      slvx_mode_reg       <= 2'b00;
      slvx_data_valid_reg <= 1'b0;
      slvx_proc_val_reg   <= 8'h00;
      slvx_data_reg       <= '0;
    end else begin
      slvx_data_valid_reg <= xfer_any;
      if (xfer_any) begin
        slvx_mode_reg     <= mode_arr[xfer_sel];
        slvx_proc_val_reg <= pv_arr[xfer_sel];
        slvx_data_reg     <= data_arr[xfer_sel];
      end
    end
  end

  assign bus.slvx_mode       = slvx_mode_reg;
  assign bus.slvx_data_valid = slvx_data_valid_reg;
  assign bus.slvx_proc_val   = slvx_proc_val_reg;
  assign bus.slvx_data       = slvx_data_reg;

endmodule

// File: tb/tb_arbiter.sv
// Bench for arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a grant-level model.
module tb_arbiter;
  localparam int DW = 32;
`ifdef ARBITER_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbiter_if #(.DW(DW)) bus ();
  arbiter #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which slave owns the stream (-1 none), who got it last, last forwarded beat.
  int            m_grant = -1;
  int            m_last  = 1;
  logic [DW-1:0] m_data  = '0;
  logic [1:0]    m_mode  = 2'b00;
  logic [7:0]    m_pv    = 8'h00;
  logic          m_xv    = 1'b0;

  logic          v_s [2];
  logic [DW-1:0] d_s [2];
  logic [1:0]    md_s [2];
  logic [7:0]    p_s [2];
  logic          e_rdy [2];

  initial begin
    forever begin
      @(negedge clk);
      v_s[0] = bus.slv0_data_valid; d_s[0] = bus.slv0_data;
      md_s[0] = bus.slv0_mode;      p_s[0] = bus.slv0_proc_valid;
      v_s[1] = bus.slv1_data_valid; d_s[1] = bus.slv1_data;
      md_s[1] = bus.slv1_mode;      p_s[1] = bus.slv1_proc_valid;
      for (int i = 0; i < 2; i++)
        e_rdy[i] = (m_grant == i) && !bus.fifo_full && !bus.mstr0_cmplt;
      chk("m_ready0", bus.slv0_ready, e_rdy[0]);
      chk("m_ready1", bus.slv1_ready, e_rdy[1]);
      chk("m_xvalid", bus.slvx_data_valid, m_xv);
      chk("m_xdata", bus.slvx_data, m_data);
      chk("m_xmode", bus.slvx_mode, m_mode);
      chk("m_xpv", bus.slvx_proc_val, m_pv);
      // advance the model across the coming rising edge
      if (rst) begin
        m_grant = -1; m_last = 1; m_data = '0; m_mode = 2'b00; m_pv = 8'h00; m_xv = 1'b0;
      end else begin
        m_xv = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if (e_rdy[i] && v_s[i]) begin
            m_xv = 1'b1; m_data = d_s[i]; m_mode = md_s[i]; m_pv = p_s[i];
          end
        end
        if (m_grant < 0) begin
          if (v_s[0] && v_s[1]) m_grant = FIXED ? 0 : 1 - m_last;
          else if (v_s[0])      m_grant = 0;
          else if (v_s[1])      m_grant = 1;
          if (m_grant >= 0) m_last = m_grant;
        end else if (bus.mstr0_cmplt || !v_s[m_grant]) begin
          m_grant = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input int i, input logic v, input logic [DW-1:0] d,
                       input logic [1:0] m, input logic [7:0] p);
    if (i == 0) begin
      bus.slv0_data_valid = v; bus.slv0_data = d; bus.slv0_mode = m; bus.slv0_proc_valid = p;
    end else begin
      bus.slv1_data_valid = v; bus.slv1_data = d; bus.slv1_mode = m; bus.slv1_proc_valid = p;
    end
  endtask

  task automatic chk_out(input string name, input logic xv, input logic [DW-1:0] d,
                         input logic r0, input logic r1);
    chk({name, "_xv"}, bus.slvx_data_valid, xv);
    chk({name, "_data"}, bus.slvx_data, d);
    chk({name, "_r0"}, bus.slv0_ready, r0);
    chk({name, "_r1"}, bus.slv1_ready, r1);
  endtask

  localparam int DROP_G = FIXED ? 0 : 1;

  logic          rv [2];
  logic          rx [2];
  logic [DW-1:0] rd [2];
  logic [1:0]    rm [2];
  logic [7:0]    rp [2];

  initial begin
    bus.mstr0_cmplt = 1'b0;
    bus.fifo_full   = 1'b0;
    set_s(0, 1'b0, '0, 2'b00, 8'h00);
    set_s(1, 1'b0, '0, 2'b00, 8'h00);

    // reset held for two edges
    tick(); tick();
    @(negedge clk);
    chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_mode", bus.slvx_mode, 2'b00);
    chk("rst_pv", bus.slvx_proc_val, 8'h00);
    tick(); rst = 1'b0;
    tick();
    @(negedge clk);
    chk_out("idle", 1'b0, 32'h0, 1'b0, 1'b0);

    // single slave stream
    tick(); set_s(0, 1'b1, 32'h2DAAD83D, 2'b10, 8'hFF);
    @(negedge clk); chk_out("ss_pre", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    @(negedge clk); chk_out("ss_grant", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); bus.slv0_data = 32'hF9B550E1;
    @(negedge clk); chk_out("ss_w1", 1'b1, 32'h2DAAD83D, 1'b1, 1'b0);
    chk("ss_mode", bus.slvx_mode, 2'b10);
    chk("ss_pv", bus.slvx_proc_val, 8'hFF);
    tick(); bus.slv0_data_valid = 1'b0;
    @(negedge clk); chk_out("ss_w2", 1'b1, 32'hF9B550E1, 1'b1, 1'b0);
    tick();
    @(negedge clk); chk_out("ss_end", 1'b0, 32'hF9B550E1, 1'b0, 1'b0);

    // contention from a fresh reset
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0;
    set_s(0, 1'b1, 32'hA0A0A0A0, 2'b01, 8'h0F);
    set_s(1, 1'b1, 32'hB1B1B1B1, 2'b11, 8'hF0);
    @(negedge clk); chk_out("ct_idle", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    @(negedge clk); chk_out("ct_g0", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); bus.mstr0_cmplt = 1'b1;
    @(negedge clk); chk_out("ct_cmplt", 1'b1, 32'hA0A0A0A0, 1'b0, 1'b0);
    tick(); bus.mstr0_cmplt = 1'b0;
    @(negedge clk); chk_out("ct_bubble", 1'b0, 32'hA0A0A0A0, 1'b0, 1'b0);
    tick();
    @(negedge clk); chk_out("ct_regrant", 1'b0, 32'hA0A0A0A0, FIXED, !FIXED);
    tick(); set_s(0, 1'b0, '0, 2'b00, 8'h00); set_s(1, 1'b0, '0, 2'b00, 8'h00);
    @(negedge clk);
    chk_out("ct_beat", 1'b1, FIXED ? 32'hA0A0A0A0 : 32'hB1B1B1B1, FIXED, !FIXED);
    chk("ct_mode", bus.slvx_mode, FIXED ? 2'b01 : 2'b11);
    tick();

    // back-pressure for three cycles mid-stream
    tick(); set_s(0, 1'b1, 32'hC0DE0000, 2'b00, 8'h33);
    tick();
    tick(); bus.slv0_data = 32'hC0DE0001; bus.fifo_full = 1'b1;
    @(negedge clk); chk_out("bp_w0", 1'b1, 32'hC0DE0000, 1'b0, 1'b0);
    tick();
    @(negedge clk); chk_out("bp_f1", 1'b0, 32'hC0DE0000, 1'b0, 1'b0);
    tick();
    @(negedge clk); chk_out("bp_f2", 1'b0, 32'hC0DE0000, 1'b0, 1'b0);
    tick(); bus.fifo_full = 1'b0;
    @(negedge clk); chk_out("bp_rel", 1'b0, 32'hC0DE0000, 1'b1, 1'b0);
    tick(); bus.slv0_data_valid = 1'b0;
    @(negedge clk); chk_out("bp_w1", 1'b1, 32'hC0DE0001, 1'b1, 1'b0);
    tick();
    @(negedge clk); chk_out("bp_once", 1'b0, 32'hC0DE0001, 1'b0, 1'b0);

    // granted slave drops out while the other waits
    tick();
    set_s(0, 1'b1, 32'h11111111, 2'b01, 8'h01);
    set_s(1, 1'b1, 32'h22222222, 2'b10, 8'h02);
    tick();
    @(negedge clk); chk_out("do_grant", 1'b0, 32'hC0DE0001, DROP_G == 0, DROP_G == 1);
    tick(); set_s(DROP_G, 1'b0, '0, 2'b00, 8'h00);
    @(negedge clk); chk_out("do_drop", 1'b1, DROP_G == 0 ? 32'h11111111 : 32'h22222222,
                            DROP_G == 0, DROP_G == 1);
    tick();
    @(negedge clk); chk_out("do_idle", 1'b0, DROP_G == 0 ? 32'h11111111 : 32'h22222222,
                            1'b0, 1'b0);
    tick();
    @(negedge clk); chk_out("do_other", 1'b0, DROP_G == 0 ? 32'h11111111 : 32'h22222222,
                            DROP_G == 1, DROP_G == 0);
    tick(); set_s(1 - DROP_G, 1'b0, '0, 2'b00, 8'h00);
    @(negedge clk); chk_out("do_beat", 1'b1, DROP_G == 0 ? 32'h22222222 : 32'h11111111,
                            DROP_G == 1, DROP_G == 0);
    tick();

    // reset while slave 1 is streaming
    tick(); set_s(1, 1'b1, 32'hE0E0E0E0, 2'b01, 8'h55);
    tick();
    tick(); bus.slv1_data = 32'hE1E1E1E1; rst = 1'b1;
    @(negedge clk); chk_out("rm_w0", 1'b1, 32'hE0E0E0E0, 1'b0, 1'b1);
    tick();
    @(negedge clk); chk_out("rm_rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rm_mode", bus.slvx_mode, 2'b00);
    chk("rm_pv", bus.slvx_proc_val, 8'h00);
    tick(); rst = 1'b0; set_s(1, 1'b0, '0, 2'b00, 8'h00);

    // random traffic; slaves hold their beat until it is accepted
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rd[i] = '0; rm[i] = 2'b00; rp[i] = 8'h00;
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rx[0] = bus.slv0_ready & bus.slv0_data_valid;
      rx[1] = bus.slv1_ready & bus.slv1_data_valid;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] || rx[i]) begin
          rv[i] = ($urandom_range(0, 99) < 60);
          rd[i] = $urandom;
          rm[i] = 2'($urandom_range(0, 3));
          rp[i] = 8'($urandom_range(0, 255));
        end else if ($urandom_range(0, 99) < 4) begin
          rv[i] = 1'b0;
        end
        set_s(i, rv[i], rd[i], rm[i], rp[i]);
      end
      bus.fifo_full   = ($urandom_range(0, 99) < 30);
      bus.mstr0_cmplt = ($urandom_range(0, 99) < 6);
      rst             = ($urandom_range(0, 199) < 1);
    end
    rst = 1'b0;
    tick();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
